// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C slave engine: FSM state encoding,
// default device address and the bus-level ACK/NACK values.
package i2c_slave_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h30;
  localparam logic       ACK_BIT          = 1'b0;
  localparam logic       NACK_BIT         = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_PTR_BYTE,
    ST_PTR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_WAIT_STOP
  } engineState_t;

endpackage

// File: rtl/i2c_slave_engine_if.sv
// Bundles the I2C pins and the register-file access port of the slave engine.
interface i2c_slave_engine_if;

  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] addr;
  logic [7:0] dataToReg;
  logic       writeEn;
  logic [7:0] dataFromReg;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, dataFromReg,
    output sda_oe, addr, dataToReg, writeEn, busy
  );

  modport master (
    output scl_in, sda_in, dataFromReg,
    input  sda_oe, addr, dataToReg, writeEn, busy
  );

endinterface

// File: rtl/i2c_line_filter.sv
// Cleans one asynchronous bus line: 2-flop synchronizer, deglitcher that needs
// FILTER_LEN consecutive new samples, and one-clock rise/fall pulses.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lineIn,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic [3:0] runCnt;

  // Pulses are issued in the same clock the filtered level flips, so level
  // and its edge pulse are always seen together downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      level  <= 1'b1;
      runCnt <= 4'd0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= lineIn;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        runCnt <= 4'd0;
      end else if (runCnt == 4'(FILTER_LEN - 1)) begin
        level  <= sync2;
        runCnt <= 4'd0;
        rise   <= sync2;
        fall   <= ~sync2;
      end else begin
        runCnt <= runCnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_engine.sv
// I2C slave protocol engine: decodes START/STOP, matches the device address,
// keeps an auto-incrementing register pointer and strobes writes / serializes reads.
module i2c_slave_engine
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEFAULT_DEV_ADDR,
  parameter int         FILTER_LEN = 3
) (
  input logic               clk,
  input logic               rst_n,
  i2c_slave_engine_if.slave bus
);

  logic sclLevel, sclRise, sclFall;
  logic sdaLevel, sdaRise, sdaFall;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) sclFilter (
    .clk    (clk),
    .rst_n  (rst_n),
    .lineIn (bus.scl_in),
    .level  (sclLevel),
    .rise   (sclRise),
    .fall   (sclFall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) sdaFilter (
    .clk    (clk),
    .rst_n  (rst_n),
    .lineIn (bus.sda_in),
    .level  (sdaLevel),
    .rise   (sdaRise),
    .fall   (sdaFall)
  );

  engineState_t state, stateNext;
  logic [2:0]   bitCnt, bitCntNext;
  logic         byteDone, byteDoneNext;
  logic [7:0]   shiftReg, shiftNext;
  logic         rwBit, rwNext;
  logic [7:0]   ptr, ptrNext;
  logic         oe, oeNext;
  logic         we, weNext;
  logic [7:0]   dataReg, dataNext;
  logic         busyReg, busyNext;
  logic         incPending, incPendingNext;
  logic         startCond, stopCond;

  assign startCond = sdaFall & sclLevel;
  assign stopCond  = sdaRise & sclLevel;

  assign bus.sda_oe    = oe;
  assign bus.addr      = ptr;
  assign bus.dataToReg = dataReg;
  assign bus.writeEn   = we;
  assign bus.busy      = busyReg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bitCnt     <= 3'd0;
      byteDone   <= 1'b0;
      shiftReg   <= 8'h00;
      rwBit      <= 1'b0;
      ptr        <= 8'h00;
      oe         <= 1'b0;
      we         <= 1'b0;
      dataReg    <= 8'h00;
      busyReg    <= 1'b0;
      incPending <= 1'b0;
    end else begin
      state      <= stateNext;
      bitCnt     <= bitCntNext;
      byteDone   <= byteDoneNext;
      shiftReg   <= shiftNext;
      rwBit      <= rwNext;
      ptr        <= ptrNext;
      oe         <= oeNext;
      we         <= weNext;
      dataReg    <= dataNext;
      busyReg    <= busyNext;
      incPending <= incPendingNext;
    end
  end

  // The write pointer bumps two clocks after the strobe so addr/dataToReg
  // hold for the strobe clock and the one after it.
  always_comb begin
    stateNext      = state;
    bitCntNext     = bitCnt;
    byteDoneNext   = byteDone;
    shiftNext      = shiftReg;
    rwNext         = rwBit;
    oeNext         = oe;
    weNext         = 1'b0;
    dataNext       = dataReg;
    busyNext       = busyReg;
    incPendingNext = we;
    ptrNext        = incPending ? ptr + 8'd1 : ptr;

    if (stopCond) begin
      stateNext    = ST_IDLE;
      oeNext       = 1'b0;
      busyNext     = 1'b0;
      bitCntNext   = 3'd0;
      byteDoneNext = 1'b0;
    end else if (startCond) begin
      stateNext    = ST_DEV_ADDR;
      bitCntNext   = 3'd0;
      byteDoneNext = 1'b0;
    end else begin
      case (state)
        ST_DEV_ADDR, ST_PTR_BYTE, ST_WR_BYTE: begin
          if (sclRise && !byteDone) begin
            shiftNext    = {shiftReg[6:0], sdaLevel};
            bitCntNext   = bitCnt + 3'd1;
            byteDoneNext = (bitCnt == 3'd7);
          end else if (sclFall && byteDone) begin
            byteDoneNext = 1'b0;
            oeNext       = 1'b1;
            if (state == ST_DEV_ADDR) begin
              if (shiftReg[7:1] == DEV_ADDR) begin
                stateNext = ST_DEV_ACK;
                busyNext  = 1'b1;
                rwNext    = shiftReg[0];
              end else begin
                stateNext = ST_WAIT_STOP;
                oeNext    = 1'b0;
              end
            end else if (state == ST_PTR_BYTE) begin
              ptrNext   = shiftReg;
              stateNext = ST_PTR_ACK;
            end else begin
              dataNext  = shiftReg;
              weNext    = 1'b1;
              stateNext = ST_WR_ACK;
            end
          end
        end
        ST_DEV_ACK: begin
          if (sclFall) begin
            bitCntNext = 3'd0;
            if (rwBit) begin
              shiftNext = bus.dataFromReg;
              oeNext    = ~bus.dataFromReg[7];
              stateNext = ST_RD_BYTE;
            end else begin
              oeNext    = 1'b0;
              stateNext = ST_PTR_BYTE;
            end
          end
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          if (sclFall) begin
            oeNext     = 1'b0;
            bitCntNext = 3'd0;
            stateNext  = ST_WR_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (sclRise && !byteDone) begin
            bitCntNext   = bitCnt + 3'd1;
            byteDoneNext = (bitCnt == 3'd7);
          end else if (sclFall) begin
            if (byteDone) begin
              oeNext       = 1'b0;
              byteDoneNext = 1'b0;
              stateNext    = ST_RD_ACK;
            end else begin
              shiftNext = {shiftReg[6:0], 1'b0};
              oeNext    = ~shiftReg[6];
            end
          end
        end
        ST_RD_ACK: begin
          // Pointer moves on the ACK rise; the next byte loads half a period later.
          if (sclRise) begin
            if (sdaLevel == ACK_BIT) begin
              ptrNext = ptr + 8'd1;
            end else begin
              stateNext = ST_WAIT_STOP;
            end
          end else if (sclFall) begin
            shiftNext  = bus.dataFromReg;
            oeNext     = ~bus.dataFromReg[7];
            bitCntNext = 3'd0;
            stateNext  = ST_RD_BYTE;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_engine.sv
// Directed bench for i2c_slave_engine: drives an open-drain I2C master model
// and checks register-port activity and slave SDA behaviour.
module tb_i2c_slave_engine;
  import i2c_slave_pkg::*;

  localparam int QTR        = 10;
  localparam int OP_START   = 0;
  localparam int OP_STOP    = 1;
  localparam int OP_WRITE   = 2;
  localparam int OP_READ    = 3;
  localparam int OP_PARTIAL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       masterScl;
  logic       masterSda;
  logic [7:0] rdPipe;
  int         total = 0;
  int         bad = 0;
  int         oeClocks = 0;
  int         wePulseBad = 0;
  logic       weLast = 1'b0;
  logic [7:0] weAddr[$];
  logic [7:0] weData[$];

  i2c_slave_engine_if bus();

  i2c_slave_engine #(.DEV_ADDR(7'h30), .FILTER_LEN(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wire sdaLine = masterSda & ~bus.sda_oe;
  assign bus.scl_in = masterScl;
  assign bus.sda_in = sdaLine;

  // Register file model with a two-clock read latency: data = addr + 0xA0.
  always @(posedge clk) begin
    rdPipe          <= bus.addr + 8'hA0;
    bus.dataFromReg <= rdPipe;
  end

  // Record every write strobe and watch for strobes longer than one clock.
  always @(negedge clk) begin
    if (bus.writeEn) begin
      weAddr.push_back(bus.addr);
      weData.push_back(bus.dataToReg);
      if (weLast) wePulseBad = wePulseBad + 1;
    end
    weLast = bus.writeEn;
    if (bus.sda_oe) oeClocks = oeClocks + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // count: glitch bit index for OP_WRITE, number of whole bits for OP_PARTIAL.
  task automatic applyStimulus(input int op, input logic [7:0] txByte,
                               input logic masterAck, input int count,
                               output logic [7:0] rxByte, output logic slaveAck);
    rxByte   = 8'h00;
    slaveAck = 1'b1;
    if (op == OP_START) begin
      masterSda = 1'b1;
      repeat (QTR) @(posedge clk);
      masterScl = 1'b1;
      repeat (QTR) @(posedge clk);
      masterSda = 1'b0;
      repeat (QTR) @(posedge clk);
      masterScl = 1'b0;
      repeat (QTR) @(posedge clk);
    end else if (op == OP_STOP) begin
      masterSda = 1'b0;
      repeat (QTR) @(posedge clk);
      masterScl = 1'b1;
      repeat (QTR) @(posedge clk);
      masterSda = 1'b1;
      repeat (QTR) @(posedge clk);
    end else if (op == OP_WRITE || op == OP_PARTIAL) begin
      for (int i = 0; i < 8; i++) begin
        if (op == OP_PARTIAL && i == count) break;
        masterSda = txByte[7-i];
        repeat (QTR) @(posedge clk);
        masterScl = 1'b1;
        if (op == OP_WRITE && i == count) begin
          repeat (QTR) @(posedge clk);
          masterScl = 1'b0;
          @(posedge clk);
          masterScl = 1'b1;
          repeat (QTR - 1) @(posedge clk);
        end else begin
          repeat (2 * QTR) @(posedge clk);
        end
        masterScl = 1'b0;
        repeat (QTR) @(posedge clk);
      end
      if (op == OP_PARTIAL) begin
        masterSda = (count < 8) ? txByte[7-count] : 1'b1;
        repeat (QTR) @(posedge clk);
        masterScl = 1'b1;
        repeat (QTR) @(posedge clk);
      end else begin
        masterSda = 1'b1;
        repeat (QTR) @(posedge clk);
        masterScl = 1'b1;
        repeat (QTR) @(posedge clk);
        slaveAck = sdaLine;
        repeat (QTR) @(posedge clk);
        masterScl = 1'b0;
        repeat (QTR) @(posedge clk);
      end
    end else if (op == OP_READ) begin
      masterSda = 1'b1;
      for (int i = 0; i < 8; i++) begin
        repeat (QTR) @(posedge clk);
        masterScl = 1'b1;
        repeat (QTR) @(posedge clk);
        rxByte[7-i] = sdaLine;
        repeat (QTR) @(posedge clk);
        masterScl = 1'b0;
        repeat (QTR) @(posedge clk);
      end
      masterSda = masterAck;
      repeat (QTR) @(posedge clk);
      masterScl = 1'b1;
      repeat (2 * QTR) @(posedge clk);
      masterScl = 1'b0;
      repeat (QTR) @(posedge clk);
      masterSda = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rx;
    logic       ack;
    int         weBase;
    int         oeBase;
    logic [7:0] t1Data[4];
    logic [7:0] t4Data[3];
    logic [7:0] t4Addr[3];

    t1Data = '{8'h12, 8'h34, 8'h56, 8'h78};
    t4Data = '{8'h11, 8'h22, 8'h33};
    t4Addr = '{8'hFE, 8'hFF, 8'h00};

    rst_n     = 1'b0;
    masterScl = 1'b1;
    masterSda = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rstSdaOe", bus.sda_oe, 0);
    checkOutput("rstWriteEn", bus.writeEn, 0);
    checkOutput("rstAddr", bus.addr, 8'h00);
    checkOutput("rstDataToReg", bus.dataToReg, 8'h00);
    checkOutput("rstBusy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    $display("[TB] burst write of four bytes from pointer 0x00");
    weBase = weAddr.size();
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h60, 1'b0, -1, rx, ack);
    checkOutput("t1DevAck", ack, ACK_BIT);
    checkOutput("t1Busy", bus.busy, 1);
    applyStimulus(OP_WRITE, 8'h00, 1'b0, -1, rx, ack);
    checkOutput("t1PtrAck", ack, ACK_BIT);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_WRITE, t1Data[i], 1'b0, -1, rx, ack);
      checkOutput("t1DataAck", ack, ACK_BIT);
    end
    applyStimulus(OP_STOP, 8'h00, 1'b0, -1, rx, ack);
    checkOutput("t1BusyAfterStop", bus.busy, 0);
    checkOutput("t1WriteCount", weAddr.size() - weBase, 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1WriteAddr", weAddr[weBase+i], i);
      checkOutput("t1WriteData", weData[weBase+i], t1Data[i]);
    end

    $display("[TB] pointer 0x05, repeated START, read two bytes");
    weBase = weAddr.size();
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h60, 1'b0, -1, rx, ack);
    checkOutput("t2DevAckW", ack, ACK_BIT);
    applyStimulus(OP_WRITE, 8'h05, 1'b0, -1, rx, ack);
    checkOutput("t2PtrAck", ack, ACK_BIT);
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h61, 1'b0, -1, rx, ack);
    checkOutput("t2DevAckR", ack, ACK_BIT);
    applyStimulus(OP_READ, 8'h00, ACK_BIT, -1, rx, ack);
    checkOutput("t2Read0", rx, 8'hA5);
    applyStimulus(OP_READ, 8'h00, NACK_BIT, -1, rx, ack);
    checkOutput("t2Read1", rx, 8'hA6);
    checkOutput("t2OeAfterNack", bus.sda_oe, 0);
    applyStimulus(OP_STOP, 8'h00, 1'b0, -1, rx, ack);
    checkOutput("t2AddrEnd", bus.addr, 8'h06);
    checkOutput("t2NoWrites", weAddr.size() - weBase, 0);

    $display("[TB] foreign address 0x31 is ignored");
    weBase = weAddr.size();
    oeBase = oeClocks;
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h62, 1'b0, -1, rx, ack);
    checkOutput("t3DevNack", ack, NACK_BIT);
    checkOutput("t3Busy", bus.busy, 0);
    applyStimulus(OP_WRITE, 8'h00, 1'b0, -1, rx, ack);
    checkOutput("t3DataNack", ack, NACK_BIT);
    applyStimulus(OP_STOP, 8'h00, 1'b0, -1, rx, ack);
    checkOutput("t3OeClocks", oeClocks - oeBase, 0);
    checkOutput("t3NoWrites", weAddr.size() - weBase, 0);

    $display("[TB] pointer wrap from 0xFE");
    weBase = weAddr.size();
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h60, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'hFE, 1'b0, -1, rx, ack);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_WRITE, t4Data[i], 1'b0, -1, rx, ack);
    end
    applyStimulus(OP_STOP, 8'h00, 1'b0, -1, rx, ack);
    checkOutput("t4WriteCount", weAddr.size() - weBase, 3);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4WriteAddr", weAddr[weBase+i], t4Addr[i]);
      checkOutput("t4WriteData", weData[weBase+i], t4Data[i]);
    end

    $display("[TB] reset while the slave drives ACK");
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_PARTIAL, 8'h60, 1'b0, 8, rx, ack);
    checkOutput("t5AckDriven", bus.sda_oe, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5AsyncRelease", bus.sda_oe, 0);
    repeat (5) @(posedge clk);
    masterScl = 1'b1;
    masterSda = 1'b1;
    repeat (10) @(posedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    $display("[TB] reset during the 4th data bit");
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h60, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h40, 1'b0, -1, rx, ack);
    checkOutput("t5PtrLoaded", bus.addr, 8'h40);
    weBase = weAddr.size();
    applyStimulus(OP_PARTIAL, 8'hF0, 1'b0, 3, rx, ack);
    rst_n = 1'b0;
    #1;
    checkOutput("t5MidBitOe", bus.sda_oe, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5AddrReset", bus.addr, 8'h00);
    checkOutput("t5BusyReset", bus.busy, 0);
    repeat (2) @(posedge clk);
    masterScl = 1'b1;
    masterSda = 1'b1;
    repeat (10) @(posedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    checkOutput("t5NoWrite", weAddr.size() - weBase, 0);
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h60, 1'b0, -1, rx, ack);
    checkOutput("t5AfterDevAck", ack, ACK_BIT);
    applyStimulus(OP_WRITE, 8'h20, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h9C, 1'b0, -1, rx, ack);
    checkOutput("t5AfterDataAck", ack, ACK_BIT);
    applyStimulus(OP_STOP, 8'h00, 1'b0, -1, rx, ack);
    checkOutput("t5AfterCount", weAddr.size() - weBase, 1);
    checkOutput("t5AfterAddr", weAddr[weBase], 8'h20);
    checkOutput("t5AfterData", weData[weBase], 8'h9C);

    $display("[TB] one-clock SCL glitch inside a data bit");
    weBase = weAddr.size();
    applyStimulus(OP_START, 8'h00, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h60, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'h70, 1'b0, -1, rx, ack);
    applyStimulus(OP_WRITE, 8'hA5, 1'b0, 3, rx, ack);
    checkOutput("t6GlitchAck", ack, ACK_BIT);
    applyStimulus(OP_WRITE, 8'h3C, 1'b0, -1, rx, ack);
    applyStimulus(OP_STOP, 8'h00, 1'b0, -1, rx, ack);
    checkOutput("t6WriteCount", weAddr.size() - weBase, 2);
    checkOutput("t6Addr0", weAddr[weBase], 8'h70);
    checkOutput("t6Data0", weData[weBase], 8'hA5);
    checkOutput("t6Addr1", weAddr[weBase+1], 8'h71);
    checkOutput("t6Data1", weData[weBase+1], 8'h3C);

    checkOutput("wePulseWidth", wePulseBad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
